// File: rtl/note_sched.sv
// Note scheduler: queues {lane, duration} requests and plays them one at a time,
// advancing each note on tick strobes and pulsing note_done when it completes.
module note_sched #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_en,
  input  logic       in_valid,
  input  logic [1:0] in_lane,
  input  logic [7:0] in_dur,
  output logic       in_ready,
  input  logic       abort,
  output logic [3:0] lane_active,
  output logic [7:0] note_count,
  output logic       note_done,
  output logic [1:0] done_lane,
  output logic       busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [1:0]      cur_lane_q, cur_lane_d;
  logic [7:0]      cur_dur_q, cur_dur_d;
  logic [7:0]      note_count_q, note_count_d;
  logic [9:0]      mem [FIFO_DEPTH];

  logic            empty, full, push, pop;
  logic [7:0]      last;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign in_ready = !full && !abort;
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == IDLE) && !empty && !abort;

  // Duration 0 stands for 256 ticks, so the terminal count saturates at 255.
  assign last = (cur_dur_q == 8'd0) ? 8'd255 : cur_dur_q - 8'd1;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    cur_lane_d   = cur_lane_q;
    cur_dur_d    = cur_dur_q;
    note_count_d = note_count_q;

    if (abort) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      state_d      = IDLE;
      note_count_d = 8'd0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            rd_ptr_d     = rd_ptr_q + AW'(1);
            cur_lane_d   = mem[rd_ptr_q][9:8];
            cur_dur_d    = mem[rd_ptr_q][7:0];
            note_count_d = 8'd0;
            state_d      = RUN;
          end
        end
        RUN: begin
          if (tick_en) begin
            if (note_count_q == last) begin
              note_count_d = 8'd0;
              state_d      = DONE;
            end else begin
              note_count_d = note_count_q + 8'd1;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cur_lane_q   <= 2'd0;
      cur_dur_q    <= 8'd0;
      note_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cur_lane_q   <= cur_lane_d;
      cur_dur_q    <= cur_dur_d;
      note_count_q <= note_count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {in_lane, in_dur};
  end

  assign lane_active = (state_q == RUN) ? (4'b0001 << cur_lane_q) : 4'b0000;
  assign note_count  = note_count_q;
  assign note_done   = (state_q == DONE);
  assign done_lane   = note_done ? cur_lane_q : 2'd0;
  assign busy        = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_note_sched.sv
// Directed self-checking bench for note_sched with hand-computed expectations.
module tb_note_sched;
  logic       clk = 1'b0;
  logic       reset, tick_en, in_valid, abort;
  logic [1:0] in_lane;
  logic [7:0] in_dur;
  logic       in_ready, note_done, busy;
  logic [3:0] lane_active;
  logic [7:0] note_count;
  logic [1:0] done_lane;

  int tests = 0;
  int fails = 0;
  logic prev_done = 1'b0;

  note_sched #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .tick_en(tick_en), .in_valid(in_valid),
    .in_lane(in_lane), .in_dur(in_dur), .in_ready(in_ready), .abort(abort),
    .lane_active(lane_active), .note_count(note_count), .note_done(note_done),
    .done_lane(done_lane), .busy(busy)
  );

  always #5 clk = ~clk;

  // Continuous invariants: no back-to-back note_done, lane_active one-hot or zero.
  always @(negedge clk) begin
    tests++;
    if (note_done && prev_done) begin
      fails++;
      $display("FAIL done_twice: note_done high two cycles in a row, required single pulse");
    end
    tests++;
    if (!$onehot0(lane_active)) begin
      fails++;
      $display("FAIL lane_onehot: lane_active=%b, required one-hot or zero", lane_active);
    end
    prev_done = note_done;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick_en = 1'b0; in_valid = 1'b0; abort = 1'b0;
    in_lane = 2'd0; in_dur = 8'd0;
    #1;
    tests++;
    if ({lane_active, note_count, note_done, done_lane, busy} !== 16'd0) begin
      fails++;
      $display("FAIL reset_outputs: lane=%b cnt=%0d done=%b dl=%0d busy=%b, required all 0",
               lane_active, note_count, note_done, done_lane, busy);
    end
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    cyc();
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: in_ready=%b busy=%b, required 1 0", in_ready, busy);
    end
    $display("[TB] reset done");
  endtask

  task automatic test_single();
    tick_en = 1'b1; in_valid = 1'b1; in_lane = 2'd2; in_dur = 8'd3;
    cyc();
    in_valid = 1'b0;
    tests++;
    if (lane_active !== 4'b0000 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_push: lane=%b busy=%b, required 0000 1", lane_active, busy);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      tests++;
      if (lane_active !== 4'b0100 || note_count !== 8'(i) || note_done !== 1'b0) begin
        fails++;
        $display("FAIL single_run%0d: lane=%b cnt=%0d done=%b, required 0100 %0d 0",
                 i, lane_active, note_count, note_done, i);
      end
    end
    cyc();
    tests++;
    if (note_done !== 1'b1 || done_lane !== 2'd2 || lane_active !== 4'b0000 || note_count !== 8'd0) begin
      fails++;
      $display("FAIL single_done: done=%b dl=%0d lane=%b cnt=%0d, required 1 2 0000 0",
               note_done, done_lane, lane_active, note_count);
    end
    cyc();
    tests++;
    if (note_done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_idle: done=%b busy=%b, required 0 0", note_done, busy);
    end
    $display("[TB] single note lane 2 dur 3 done");
  endtask

  task automatic test_dur0();
    tick_en = 1'b1; in_valid = 1'b1; in_lane = 2'd1; in_dur = 8'd0;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      cyc();
      tests++;
      if (lane_active !== 4'b0010 || note_count !== 8'(i) || note_done !== 1'b0) begin
        fails++;
        $display("FAIL dur0_run%0d: lane=%b cnt=%0d done=%b, required 0010 %0d 0",
                 i, lane_active, note_count, note_done, i);
      end
    end
    cyc();
    tests++;
    if (note_done !== 1'b1 || done_lane !== 2'd1 || note_count !== 8'd0) begin
      fails++;
      $display("FAIL dur0_done: done=%b dl=%0d cnt=%0d, required 1 1 0", note_done, done_lane, note_count);
    end
    cyc();
    tests++;
    if (note_done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL dur0_idle: done=%b busy=%b, required 0 0", note_done, busy);
    end
    $display("[TB] dur 0 note (256 ticks) done");
  endtask

  task automatic test_backpressure();
    logic [1:0] exp_seq [5];
    logic [1:0] got_seq [8];
    int n = 0;
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3; exp_seq[3] = 2'd0; exp_seq[4] = 2'd3;
    tick_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_lane = 2'(k); in_dur = 8'd1;
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL bp_ready%0d: in_ready=%b, required 1", k, in_ready);
      end
      cyc();
    end
    in_lane = 2'd3;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (in_ready !== 1'b0 || lane_active !== 4'b0001) begin
        fails++;
        $display("FAIL bp_full%0d: in_ready=%b lane=%b, required 0 0001", k, in_ready, lane_active);
      end
      cyc();
    end
    tick_en = 1'b1;
    cyc();
    tick_en = 1'b0;
    tests++;
    if (note_done !== 1'b1 || done_lane !== 2'd0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_first_done: done=%b dl=%0d ready=%b, required 1 0 0", note_done, done_lane, in_ready);
    end
    cyc();
    tests++;
    if (in_ready !== 1'b0 || lane_active !== 4'b0000) begin
      fails++;
      $display("FAIL bp_idle: ready=%b lane=%b, required 0 0000", in_ready, lane_active);
    end
    cyc();
    tests++;
    if (in_ready !== 1'b1 || lane_active !== 4'b0010) begin
      fails++;
      $display("FAIL bp_pop: ready=%b lane=%b, required 1 0010", in_ready, lane_active);
    end
    cyc();
    in_valid = 1'b0;
    tick_en = 1'b1;
    for (int c = 0; c < 40 && busy; c++) begin
      if (note_done && n < 8) begin
        got_seq[n] = done_lane;
        n++;
      end
      cyc();
    end
    tests++;
    if (busy !== 1'b0 || n != 5) begin
      fails++;
      $display("FAIL bp_drain: busy=%b notes=%0d, required 0 5", busy, n);
    end
    for (int i = 0; i < 5 && i < n; i++) begin
      tests++;
      if (got_seq[i] !== exp_seq[i]) begin
        fails++;
        $display("FAIL bp_order%0d: done_lane=%0d, required %0d", i, got_seq[i], exp_seq[i]);
      end
    end
    $display("[TB] back-pressure with 6 requests done");
  endtask

  task automatic test_order();
    logic [1:0] lanes [3];
    int t_done [3];
    int n = 0;
    lanes[0] = 2'd0; lanes[1] = 2'd3; lanes[2] = 2'd1;
    tick_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_lane = lanes[k]; in_dur = 8'd2;
      cyc();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      if (note_done) begin
        tests++;
        if (done_lane !== lanes[n]) begin
          fails++;
          $display("FAIL order%0d: done_lane=%0d, required %0d", n, done_lane, lanes[n]);
        end
        t_done[n] = c;
        n++;
      end
      cyc();
    end
    tests++;
    if (n != 3) begin
      fails++;
      $display("FAIL order_count: notes=%0d, required 3", n);
    end
    for (int i = 1; i < n; i++) begin
      tests++;
      if (t_done[i] - t_done[i-1] != 4) begin
        fails++;
        $display("FAIL order_gap%0d: period=%0d cycles, required 4", i, t_done[i] - t_done[i-1]);
      end
    end
    repeat (2) cyc();
    $display("[TB] order lanes 0,3,1 done");
  endtask

  task automatic test_abort();
    tick_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_lane = 2'(k); in_dur = 8'd5;
      cyc();
    end
    in_valid = 1'b0;
    tick_en = 1'b1;
    repeat (2) cyc();
    tests++;
    if (note_count !== 8'd2 || lane_active !== 4'b0001) begin
      fails++;
      $display("FAIL abort_pre: cnt=%0d lane=%b, required 2 0001", note_count, lane_active);
    end
    abort = 1'b1; in_valid = 1'b1; in_lane = 2'd3; in_dur = 8'd1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL abort_ready: in_ready=%b, required 0", in_ready);
    end
    cyc();
    abort = 1'b0; in_valid = 1'b0;
    tests++;
    if (lane_active !== 4'b0000 || busy !== 1'b0 || note_count !== 8'd0 || note_done !== 1'b0) begin
      fails++;
      $display("FAIL abort_post: lane=%b busy=%b cnt=%0d done=%b, required 0000 0 0 0",
               lane_active, busy, note_count, note_done);
    end
    for (int c = 0; c < 10; c++) begin
      cyc();
      tests++;
      if (note_done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL abort_quiet%0d: done=%b busy=%b, required 0 0", c, note_done, busy);
      end
    end
    $display("[TB] abort mid-run done");
  endtask

  task automatic test_async_reset();
    tick_en = 1'b1; in_valid = 1'b1; in_lane = 2'd3; in_dur = 8'd10;
    cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    tests++;
    if (lane_active !== 4'b1000 || note_count !== 8'd2) begin
      fails++;
      $display("FAIL areset_pre: lane=%b cnt=%0d, required 1000 2", lane_active, note_count);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (lane_active !== 4'b0000 || note_count !== 8'd0 || busy !== 1'b0 || note_done !== 1'b0) begin
      fails++;
      $display("FAIL areset_now: lane=%b cnt=%0d busy=%b done=%b, required 0000 0 0 0",
               lane_active, note_count, busy, note_done);
    end
    @(posedge clk);
    #3 reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      tests++;
      if (note_done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL areset_quiet%0d: done=%b busy=%b, required 0 0", c, note_done, busy);
      end
    end
    $display("[TB] async reset mid-note done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_dur0();
    test_backpressure();
    test_order();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
